// File: rtl/i2c_arb.sv
// i2c_arb: grants the I2C master command port to the init sequencer (`I2CARB_INIT_EN) or the host, and hosts an 8-bit GPIO register.
// A grant is held across bytes until a byte with last=1 completes (ack or err).
module i2c_arb #(
    parameter int INIT_LEN = 4
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] addr,
    output logic [7:0] wrdata,
    output logic       req,
    output logic       last,
    input  logic [7:0] rddata,
    input  logic       ack,
    input  logic       err,
    input  logic [7:0] hdaddr,
    input  logic [7:0] hdwrdata,
    input  logic       hdreq,
    input  logic       hdwr,
    input  logic       hdlast,
    output logic [7:0] hdrddata,
    output logic       hdack,
    output logic       hderr,
    output logic [7:0] gpio
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]  state;
    logic        gnt_init;
    logic        locked;
    logic        lock_init;
    logic        init_pend;
    logic [15:0] rom_ent;

`ifdef I2CARB_INIT_EN
    localparam int IW = $clog2(INIT_LEN + 1);
    logic [IW-1:0] idx;

    // Each entry is {dev[6:0], data[7:0], last}; the final entry closes the transaction.
    function automatic logic [15:0] rom(input logic [IW-1:0] i);
        logic [6:0] dev;
        logic [7:0] dat;
        logic       lst;
        dev = 7'h50 + 7'(i);
        dat = 8'hA0 + 8'(i);
        lst = (i == IW'(INIT_LEN - 1));
        return {dev, dat, lst};
    endfunction

    assign init_pend = (idx != IW'(INIT_LEN));
    assign rom_ent   = rom(idx);
`else
    assign init_pend = 1'b0;
    assign rom_ent   = 16'h0000;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            gnt_init  <= 1'b0;
            locked    <= 1'b0;
            lock_init <= 1'b0;
            req       <= 1'b0;
            last      <= 1'b0;
            addr      <= 8'h00;
            wrdata    <= 8'h00;
            hdrddata  <= 8'h00;
            hdack     <= 1'b0;
            hderr     <= 1'b0;
            gpio      <= 8'h00;
`ifdef I2CARB_INIT_EN
            idx       <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (init_pend && (!locked || lock_init)) begin
                        gnt_init <= 1'b1;
                        req      <= 1'b1;
                        addr     <= {rom_ent[15:9], 1'b0};
                        wrdata   <= rom_ent[8:1];
                        last     <= rom_ent[0];
                        state    <= BUSY;
                    end else if (hdreq && !init_pend && (!locked || !lock_init)) begin
                        gnt_init <= 1'b0;
                        if (hdaddr[7]) begin
                            // Local GPIO: completes without touching the I2C bus or the lock.
                            if (hdwr) gpio <= hdwrdata;
                            else      hdrddata <= gpio;
                            hderr <= 1'b0;
                            hdack <= 1'b1;
                            state <= DONE;
                        end else begin
                            req    <= 1'b1;
                            addr   <= {hdaddr[6:0], ~hdwr};
                            wrdata <= hdwrdata;
                            last   <= hdlast;
                            state  <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (ack || err) begin
                        req       <= 1'b0;
                        state     <= DONE;
                        locked    <= !last;
                        lock_init <= gnt_init;
                        if (!gnt_init) begin
                            hdack <= 1'b1;
                            hderr <= err;
                            if (!err) hdrddata <= rddata;
                        end
`ifdef I2CARB_INIT_EN
                        if (gnt_init) idx <= idx + 1'b1;
`endif
                    end
                end
                DONE: begin
                    hdack <= 1'b0;
                    hderr <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_arb.sv
// Scoreboarded bench for i2c_arb: host results are queued when driven and compared at hdack.
module tb_i2c_arb;
    localparam int INIT_LEN = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] addr, wrdata, rddata, hdaddr, hdwrdata, hdrddata, gpio;
    logic       req, last, ack, err, hdreq, hdwr, hdlast, hdack, hderr;

    always #5 clk = ~clk;

    i2c_arb #(.INIT_LEN(INIT_LEN)) dut (
        .clk(clk), .rst(rst), .addr(addr), .wrdata(wrdata), .req(req), .last(last),
        .rddata(rddata), .ack(ack), .err(err), .hdaddr(hdaddr), .hdwrdata(hdwrdata),
        .hdreq(hdreq), .hdwr(hdwr), .hdlast(hdlast), .hdrddata(hdrddata),
        .hdack(hdack), .hderr(hderr), .gpio(gpio)
    );

    typedef struct packed {
        logic [7:0] rd;
        logic       er;
    } exp_t;

    exp_t       sb[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] gpio_m  = 8'h00;
    logic [7:0] rd_m    = 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pop_chk();
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_underflow", 1, 0);
        end else begin
            e = sb.pop_front();
            chk("hdrddata", hdrddata, e.rd);
            chk("hderr", hderr, e.er);
        end
    endtask

    // One host byte; the master model answers dly cycles after req rises.
    task automatic host_xfer(input logic [7:0] a, input logic wr, input logic [7:0] wd,
                             input logic lst, input logic nack, input logic both,
                             input logic [7:0] rdv, input int dly);
        exp_t e;
        logic is_gpio;
        int   drops;
        is_gpio = a[7];
        drops   = 0;
        if (is_gpio) begin
            if (wr) gpio_m = wd;
            else    rd_m   = gpio_m;
        end else if (!nack) begin
            rd_m = rdv;
        end
        e.rd = rd_m;
        e.er = !is_gpio && nack;
        sb.push_back(e);

        @(negedge clk);
        hdaddr = a; hdwr = wr; hdwrdata = wd; hdlast = lst; hdreq = 1'b1;
        @(posedge clk); #1;
        if (is_gpio) begin
            chk("gpio_no_req", req, 0);
            chk("gpio_hdack", hdack, 1);
            chk("gpio_reg", gpio, gpio_m);
        end else begin
            chk("req_rise", req, 1);
            chk("addr", addr, {a[6:0], ~wr});
            chk("wrdata", wrdata, wd);
            chk("last", last, lst);
            chk("no_early_hdack", hdack, 0);
            for (int i = 0; i < dly; i++) begin
                @(negedge clk);
                if (!req || addr != {a[6:0], ~wr} || wrdata != wd || last != lst || hdack) drops++;
            end
            chk("req_held", drops, 0);
            @(negedge clk);
            rddata = rdv; ack = !nack || both; err = nack;
            @(posedge clk); #1;
            chk("req_drop", req, 0);
            chk("hdack", hdack, 1);
        end
        pop_chk();
        @(negedge clk);
        ack = 1'b0; err = 1'b0; hdreq = 1'b0;
        @(posedge clk); #1;
        chk("hdack_one_cycle", hdack, 0);
    endtask

    initial begin
        int hd_seen;
        int cnt;
        logic got;
        rst = 1'b1; ack = 1'b0; err = 1'b0; rddata = 8'h00;
        hdaddr = 8'h00; hdwrdata = 8'h00; hdwr = 1'b0; hdlast = 1'b0; hdreq = 1'b0;
`ifdef I2CARB_INIT_EN
        hdaddr = 8'h41; hdwr = 1'b1; hdwrdata = 8'hAB; hdlast = 1'b1; hdreq = 1'b1;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", req, 0);
        chk("rst_last", last, 0);
        chk("rst_addr", addr, 8'h00);
        chk("rst_wrdata", wrdata, 8'h00);
        chk("rst_hdrddata", hdrddata, 8'h00);
        chk("rst_hdack", hdack, 0);
        chk("rst_hderr", hderr, 0);
        chk("rst_gpio", gpio, 8'h00);
        @(negedge clk);
        rst = 1'b0;

`ifdef I2CARB_INIT_EN
        hd_seen = 0;
        for (int k = 0; k < INIT_LEN; k++) begin
            got = 1'b0;
            for (int c = 0; c < 20 && !got; c++) begin
                @(negedge clk);
                if (hdack) hd_seen++;
                if (req) got = 1'b1;
            end
            chk("init_req", got, 1);
            chk("init_addr", addr, {7'h50 + 7'(k), 1'b0});
            chk("init_data", wrdata, 8'hA0 + 8'(k));
            chk("init_last", last, (k == INIT_LEN - 1));
            ack = 1'b1;
            @(negedge clk);
            ack = 1'b0;
        end
        chk("no_hdack_during_init", hd_seen, 0);
        e_push_init: begin
            exp_t e;
            rd_m = 8'h00;
            e.rd = rd_m; e.er = 1'b0;
            sb.push_back(e);
        end
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (req) got = 1'b1;
        end
        chk("init_host_req", got, 1);
        chk("init_host_addr", addr, 8'h82);
        rddata = 8'h00; ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 5 && !got; c++) begin
            @(posedge clk); #1;
            if (hdack) got = 1'b1;
        end
        chk("init_host_hdack", got, 1);
        pop_chk();
        @(negedge clk);
        hdreq = 1'b0;
        repeat (2) @(negedge clk);
`endif

        host_xfer(8'h41, 1'b1, 8'hAB, 1'b0, 1'b0, 1'b0, 8'h00, 10);
        host_xfer(8'h41, 1'b0, 8'hAB, 1'b1, 1'b0, 1'b0, 8'h42, 10);
        host_xfer(8'h41, 1'b1, 8'h11, 1'b1, 1'b1, 1'b0, 8'h99, 3);
        host_xfer(8'h33, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h77, 2);
        host_xfer(8'h80, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 8'h00, 0);
        host_xfer(8'h80, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 0);
        host_xfer(8'h7F, 1'b0, 8'hC3, 1'b1, 1'b0, 1'b0, 8'hE1, 0);

        // Stray ack while idle must not complete anything.
        @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        @(posedge clk); #1;
        chk("idle_ack_ignored", hdack, 0);

        // Reset in the middle of a host byte.
        @(negedge clk);
        hdaddr = 8'h22; hdwr = 1'b1; hdwrdata = 8'h66; hdlast = 1'b1; hdreq = 1'b1;
        @(posedge clk); #1;
        chk("mid_req", req, 1);
        repeat (3) @(negedge clk);
        rst = 1'b1; hdreq = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_req", req, 0);
        chk("mid_rst_addr", addr, 8'h00);
        chk("mid_rst_wrdata", wrdata, 8'h00);
        chk("mid_rst_last", last, 0);
        chk("mid_rst_hdrddata", hdrddata, 8'h00);
        chk("mid_rst_gpio", gpio, 8'h00);
        @(negedge clk);
        rst = 1'b0; ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        cnt = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (hdack) cnt++;
        end
        chk("late_ack_no_hdack", cnt, 0);
        chk("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
